// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction loader:
//   state_t        - loader FSM states (CHK is only entered when the build
//                    defines LOADER_CHECKSUM_EN)
//   BYTES_PER_WORD - stream bytes per instruction word
//   WORD_COUNT_W   - width of the word-count field at the head of the stream
//   is_busy()      - true for the states that accept stream bytes
// -----------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_COUNT_W   = 32;

  // States in which the loader owns the byte stream.
  function automatic logic is_busy(input state_t s);
    return (s == LEN) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// -----------------------------------------------------------------------------
// byte_to_word_packer
// Assembles little-endian 32-bit words from an accepted byte stream. Used for
// both the word-count field and the instruction words.
//
// Ports:
//   clk_i        - clock
//   rst_i        - synchronous active-high reset
//   clr_i        - synchronous clear of the byte counter and shift register
//   byte_en_i    - a byte is accepted this cycle
//   byte_i       - the accepted byte
//   word_o       - word including the byte presented this cycle (valid when
//                  word_valid_o is high)
//   word_valid_o - high on the cycle the 4th byte of a word is accepted
// -----------------------------------------------------------------------------
module byte_to_word_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q;
  logic [31:0] shift_q;

  // New bytes enter at the top and move down, so the first byte of a word
  // ends up in bits [7:0] after four shifts.
  assign word_o       = {byte_i, shift_q[31:8]};
  assign word_valid_o = byte_en_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q   <= 2'd0;
      shift_q <= 32'd0;
    end else if (byte_en_i) begin
      cnt_q   <= cnt_q + 2'd1;   // wraps 3 -> 0 at each word boundary
      shift_q <= word_o;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
// Boot-time writer for the instruction memory write port. Receives a byte
// stream (32-bit LE word count, then LE words), writes each word to
// instruction memory and holds the CPU in reset until the load completes.
//
// Build option: LOADER_CHECKSUM_EN adds a trailing checksum byte; the XOR of
// every accepted byte including the checksum must be zero, else ERROR.
//
// Parameters:
//   DEPTH_WORDS - instruction memory capacity in words; larger counts -> ERROR
//   BASE_ADDR   - byte address of word 0
//
// Ports:
//   CLK, RESET     - clock, synchronous active-high reset
//   START          - load request pulse, honoured in IDLE, DONE and ERROR
//   ByteIn/ByteValid/ByteReady - byte stream; a byte transfers on a cycle
//                    where ByteValid and ByteReady are both high. ByteReady is
//                    registered and depends only on state, never on ByteValid.
//   MemWE, MemAddress, MemWriteData - one-cycle write strobe, address, data
//   CPUReset, CPUEnable - CPU reset (held unless DONE) and PC enable
//   Busy, Done, Error   - status decodes of the loader state
//   DbgState            - current FSM state, for observation
// -----------------------------------------------------------------------------
module instruction_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        MemWE,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        CPUReset,
  output logic        CPUEnable,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [2:0]  DbgState
);

  localparam logic [WORD_COUNT_W-1:0] DEPTH_W32 = WORD_COUNT_W'(DEPTH_WORDS);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t LAST_ST = CHK;
`else
  localparam state_t LAST_ST = DONE;
`endif

  state_t                  state_q, state_d;
  logic [WORD_COUNT_W-1:0] count_q;
  logic [31:0]             index_q;
  logic                    rdy_q, we_q, cpu_rst_q, cpu_en_q, busy_q, done_q, err_q;
  logic [31:0]             addr_q, wdata_q;

  logic                    accept;
  logic                    start_go;
  logic                    pack_en;
  logic [31:0]             word;
  logic                    word_valid;

  assign accept   = ByteValid && rdy_q;
  assign start_go = START && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  // Only count and data bytes are packed; the checksum byte is not.
  assign pack_en  = accept && ((state_q == LEN) || (state_q == DATA));

  byte_to_word_packer u_packer (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .clr_i        (start_go),
    .byte_en_i    (pack_en),
    .byte_i       (ByteIn),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic [7:0] xor_all;
  assign xor_all = xor_q ^ ByteIn;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (START) state_d = LEN;
      LEN: begin
        if (word_valid) begin
          if (word == '0)              state_d = LAST_ST;
          else if (word > DEPTH_W32)   state_d = ERROR;
          else                         state_d = DATA;
        end
      end
      DATA: begin
        // count_q >= 1 here, so count_q - 1 cannot underflow.
        if (word_valid && (index_q == count_q - 32'd1)) state_d = LAST_ST;
      end
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept) state_d = (xor_all == 8'd0) ? DONE : ERROR;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      count_q   <= '0;
      index_q   <= 32'd0;
      rdy_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= BASE_ADDR;
      wdata_q   <= 32'd0;
      cpu_rst_q <= 1'b1;
      cpu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= is_busy(state_d);
      busy_q  <= is_busy(state_d);
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == ERROR);
      // CPU is released one cycle after DONE is entered (so the final write
      // lands first) and re-held on the cycle after a restart.
      cpu_en_q  <=  ((state_q == DONE) && (state_d == DONE));
      cpu_rst_q <= !((state_q == DONE) && (state_d == DONE));
      we_q    <= 1'b0;

      if (start_go) begin
        count_q <= '0;
        index_q <= 32'd0;
      end
      if ((state_q == LEN) && word_valid) count_q <= word;
      if ((state_q == DATA) && word_valid) begin
        we_q    <= 1'b1;
        addr_q  <= BASE_ADDR + (index_q << 2);
        wdata_q <= word;
        index_q <= index_q + 32'd1;
      end
`ifdef LOADER_CHECKSUM_EN
      if (start_go)    xor_q <= 8'd0;
      else if (accept) xor_q <= xor_all;
`endif
    end
  end

  assign ByteReady    = rdy_q;
  assign MemWE        = we_q;
  assign MemAddress   = addr_q;
  assign MemWriteData = wdata_q;
  assign CPUReset     = cpu_rst_q;
  assign CPUEnable    = cpu_en_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Error        = err_q;
  assign DbgState     = state_q;

endmodule

// File: tb/tb_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_loader
// Directed bench for instruction_loader (DEPTH_WORDS=256, BASE_ADDR=0).
// A per-cycle vector table covers the basic Count=2 load, START while busy,
// bytes offered in DONE and START from DONE. Hand-written sequences cover
// stalls, Count=0, oversize counts, ERROR, reset mid-load and (when built with
// LOADER_CHECKSUM_EN) the checksum byte. Every MemWE pulse is checked against
// an expected-write queue.
// -----------------------------------------------------------------------------
module tb_instruction_loader;
  import loader_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        CLK = 1'b0;
  logic        RESET, START, ByteValid;
  logic [7:0]  ByteIn;
  logic        ByteReady, MemWE, CPUReset, CPUEnable, Busy, Done, Error;
  logic [31:0] MemAddress, MemWriteData;
  logic [2:0]  DbgState;

  always #5 CLK = ~CLK;

  instruction_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ByteIn(ByteIn),
    .ByteValid(ByteValid), .ByteReady(ByteReady), .MemWE(MemWE),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .CPUReset(CPUReset), .CPUEnable(CPUEnable), .Busy(Busy),
    .Done(Done), .Error(Error), .DbgState(DbgState)
  );

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;
  int we_cnt  = 0;
  logic [63:0] exp_q[$];   // {address, data} of each expected write
  logic [63:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // ---------------- write scoreboard ----------------
  always @(negedge CLK) begin
    if (MemWE === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr %h data %h, required no write", MemAddress, MemWriteData);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", MemAddress, mon_e[63:32]);
        check("write_data", MemWriteData, mon_e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge CLK); START = 1'b0; ByteValid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge CLK); START = 1'b1; ByteValid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int tries;
    @(negedge CLK); START = 1'b0; ByteValid = 1'b1; ByteIn = b;
    tries = 0;
    while (ByteReady !== 1'b1 && tries < 50) begin
      @(negedge CLK);
      tries++;
    end
    if (tries >= 50) begin
      n_total++;
      $display("FAIL send_byte_timeout: ByteReady %b, required 1", ByteReady);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      if (gap) step();
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_rdy"},   ByteReady, 0);
    check({name, "_we"},    MemWE, 0);
    check({name, "_addr"},  MemAddress, 32'h0);
    check({name, "_wdata"}, MemWriteData, 32'h0);
    check({name, "_cpurst"}, CPUReset, 1);
    check({name, "_cpuen"}, CPUEnable, 0);
    check({name, "_busy"},  Busy, 0);
    check({name, "_done"},  Done, 0);
    check({name, "_err"},   Error, 0);
    check({name, "_state"}, DbgState, 32'(IDLE));
  endtask

  // Waits for Done; checks CPU still held on the first Done cycle and
  // released on the next one.
  task automatic wait_done(input string name);
    int n = 0;
    do begin step(); n++; end while (Done !== 1'b1 && n < 100);
    check({name, "_done"},      Done, 1);
    check({name, "_cpuheld"},   CPUReset, 1);
    step();
    check({name, "_cpurst0"},   CPUReset, 0);
    check({name, "_cpuen1"},    CPUEnable, 1);
    check({name, "_state"},     DbgState, 32'(DONE));
    check({name, "_rdy0"},      ByteReady, 0);
  endtask

  task automatic wait_error(input string name);
    int n = 0;
    do begin step(); n++; end while (Error !== 1'b1 && n < 100);
    check({name, "_err"},    Error, 1);
    check({name, "_rdy0"},   ByteReady, 0);
    check({name, "_cpurst"}, CPUReset, 1);
    check({name, "_cpuen"},  CPUEnable, 0);
    check({name, "_busy"},   Busy, 0);
  endtask

  // Count=2 load of 0x00000013 and 0x005000B3 (checksum 0xF2 when enabled).
  task automatic load_two(input string name, input bit gap);
    exp_q.push_back({32'h0, 32'h0000_0013});
    exp_q.push_back({32'h4, 32'h0050_00B3});
    pulse_start();
    send_word(32'd2, gap);
    send_word(32'h0000_0013, gap);
    send_word(32'h0050_00B3, gap);
`ifdef LOADER_CHECKSUM_EN
    if (gap) step();
    send_byte(8'hF2);
`endif
    wait_done(name);
    check({name, "_allwrites"}, exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        start, valid;
    logic [7:0]  din;
    logic        rdy, we;
    logic [31:0] addr, wdata;
    logic        cpurst, cpuen, busy, done, err;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                              input logic r, input logic we, input logic [31:0] a,
                              input logic [31:0] w, input logic crst, input logic cen,
                              input logic b, input logic dn, input logic e);
    vec_t t;
    t.start = s; t.valid = v; t.din = d; t.rdy = r; t.we = we; t.addr = a;
    t.wdata = w; t.cpurst = crst; t.cpuen = cen; t.busy = b; t.done = dn; t.err = e;
    return t;
  endfunction

  vec_t vecs[17];

  initial begin
    int we_before;
    RESET = 1'b1; START = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check_reset("reset");

`ifndef LOADER_CHECKSUM_EN
    // Row: inputs this cycle | outputs observed this cycle (registered).
    //               st v  din     rdy we addr   wdata          rst en busy done err
    vecs[0]  = mk(1, 0, 8'h00,  0, 0, 32'h0, 32'h0,          1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 8'h02,  1, 0, 32'h0, 32'h0,          1, 0, 1, 0, 0);
    vecs[2]  = mk(0, 1, 8'h00,  1, 0, 32'h0, 32'h0,          1, 0, 1, 0, 0);
    vecs[3]  = mk(0, 1, 8'h00,  1, 0, 32'h0, 32'h0,          1, 0, 1, 0, 0);
    vecs[4]  = mk(0, 1, 8'h00,  1, 0, 32'h0, 32'h0,          1, 0, 1, 0, 0);
    vecs[5]  = mk(0, 1, 8'h13,  1, 0, 32'h0, 32'h0,          1, 0, 1, 0, 0);
    vecs[6]  = mk(1, 1, 8'h00,  1, 0, 32'h0, 32'h0,          1, 0, 1, 0, 0);
    vecs[7]  = mk(0, 1, 8'h00,  1, 0, 32'h0, 32'h0,          1, 0, 1, 0, 0);
    vecs[8]  = mk(0, 1, 8'h00,  1, 0, 32'h0, 32'h0,          1, 0, 1, 0, 0);
    vecs[9]  = mk(0, 1, 8'hB3,  1, 1, 32'h0, 32'h13,         1, 0, 1, 0, 0);
    vecs[10] = mk(0, 1, 8'h00,  1, 0, 32'h0, 32'h13,         1, 0, 1, 0, 0);
    vecs[11] = mk(0, 1, 8'h50,  1, 0, 32'h0, 32'h13,         1, 0, 1, 0, 0);
    vecs[12] = mk(0, 1, 8'h00,  1, 0, 32'h0, 32'h13,         1, 0, 1, 0, 0);
    vecs[13] = mk(0, 0, 8'h00,  0, 1, 32'h4, 32'h0050_00B3,  1, 0, 0, 1, 0);
    vecs[14] = mk(0, 1, 8'hAA,  0, 0, 32'h4, 32'h0050_00B3,  0, 1, 0, 1, 0);
    vecs[15] = mk(1, 0, 8'h00,  0, 0, 32'h4, 32'h0050_00B3,  0, 1, 0, 1, 0);
    vecs[16] = mk(0, 0, 8'h00,  1, 0, 32'h4, 32'h0050_00B3,  1, 0, 1, 0, 0);
    exp_q.push_back({32'h0, 32'h0000_0013});
    exp_q.push_back({32'h4, 32'h0050_00B3});
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      check($sformatf("vec%0d_rdy", i),    ByteReady,    vecs[i].rdy);
      check($sformatf("vec%0d_we", i),     MemWE,        vecs[i].we);
      check($sformatf("vec%0d_addr", i),   MemAddress,   vecs[i].addr);
      check($sformatf("vec%0d_wdata", i),  MemWriteData, vecs[i].wdata);
      check($sformatf("vec%0d_cpurst", i), CPUReset,     vecs[i].cpurst);
      check($sformatf("vec%0d_cpuen", i),  CPUEnable,    vecs[i].cpuen);
      check($sformatf("vec%0d_busy", i),   Busy,         vecs[i].busy);
      check($sformatf("vec%0d_done", i),   Done,         vecs[i].done);
      check($sformatf("vec%0d_err", i),    Error,        vecs[i].err);
      START = vecs[i].start; ByteValid = vecs[i].valid; ByteIn = vecs[i].din;
    end
    // Reload started from DONE in the table: Count=1, word 0x12345678.
    exp_q.push_back({32'h0, 32'h1234_5678});
    send_word(32'd1, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    wait_done("reload");
    check("reload_allwrites", exp_q.size(), 0);
`else
    load_two("load_chk", 1'b0);
    // Count=1, word 0x13: XOR 01^13 = 12, so checksum 12 is good, 00 is bad.
    exp_q.push_back({32'h0, 32'h0000_0013});
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h12);
    wait_done("chk_good");
    exp_q.push_back({32'h0, 32'h0000_0013});
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h00);
    wait_error("chk_bad");
    check("chk_bad_allwrites", exp_q.size(), 0);
`endif

    // Same Count=2 stream with ByteValid toggling every other cycle.
    load_two("gap", 1'b1);

    // Count=0: straight to DONE, no writes.
    we_before = we_cnt;
    pulse_start();
    send_word(32'd0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_done("count0");
    check("count0_no_writes", we_cnt, we_before);

    // Count=257 > DEPTH_WORDS: ERROR, bytes then refused.
    pulse_start();
    send_word(32'd257, 1'b0);
    wait_error("count257");
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); START = 1'b0; ByteValid = 1'b1; ByteIn = 8'h55;
    end
    step();
    check("error_sticky",  Error, 1);
    check("error_norecv",  ByteReady, 0);
    check("error_nowrite", exp_q.size(), 0);
    pulse_start();
    step();
    check("error_restart_busy", Busy, 1);
    check("error_restart_err",  Error, 0);
    check("error_restart_rdy",  ByteReady, 1);

    // RESET after 6 of 8 data bytes: one write, then back to reset values.
    we_before = we_cnt;
    exp_q.push_back({32'h0, 32'h0000_0013});
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'hB3);
    send_byte(8'h00);
    @(negedge CLK); RESET = 1'b1; ByteValid = 1'b0;
    @(negedge CLK);
    check_reset("midreset");
    check("midreset_one_write", we_cnt, we_before + 1);
    RESET = 1'b0;
    load_two("after_reset", 1'b0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
